clk_freq_meter: RTL
===================

// Module: clk_freq_meter
// PURPOSE
//   Measures the slow clock produced by the divider stage (e.g. clk_1hz), or any slow
//   asynchronous pulse train, against the system clock. Reports period and high time in
//   clk cycles, with a one-cycle valid strobe. Flags loss of the signal with a timeout.
//   Sits next to the clock divider as its on-chip checker.
// PARAMETERS
//   CW          26          counter/output width in bits
//   TIMEOUT     60_000_000  clk cycles without a rise before timeout; must be < 2**CW
//   EXP_PERIOD  50_000_000  expected period in clk cycles (check feature only)
//   TOL         1000        allowed |period - EXP_PERIOD| (check feature only)
// PORTS
//   clk         in   1   system clock, single clock domain
//   rst         in   1   synchronous, active-high reset
//   sig_in      in   1   asynchronous signal under measurement
//   period      out  CW  clk cycles between the last two rising edges
//   high_time   out  CW  clk cycles sig was high within that period
//   meas_valid  out  1   1-cycle strobe; period/high_time updated this cycle
//   timeout     out  1   sticky: no rising edge seen within TIMEOUT cycles
//   in_tol      out  1   period within EXP_PERIOD +/- TOL (check feature)
// BEHAVIOUR
//   - Reset: all outputs 0; sync flops, edge register and counters 0; state WAIT_LOW.
//   - sig_in passes through a 2-FF synchronizer (s1) and an edge register (s_prev).
//     rise = s1 & ~s_prev. A rise is seen 2 clk edges after sig_in is sampled.
//   - FSM:
//       WAIT_LOW -> ARM   when s1==0. This blocks a false rise if sig_in is high at reset release.
//       ARM      -> MEAS  on rise. Counters cleared; no valid.
//       MEAS     -> MEAS  on rise. period <= cycles since previous rise; high_time <= cycles
//                         with s1==1 in that interval; meas_valid=1 for 1 cycle; counters restart.
//       MEAS     -> ARM   when the cycle count reaches TIMEOUT with no rise. Then timeout<=1,
//                         period<=0, high_time<=0; meas_valid stays 0.
//   - Timeout is cleared by the first rise after it (the ARM->MEAS transition).
//     A valid result needs one more rise after that.
//   - Simultaneous: a rise in the same cycle the count reaches TIMEOUT counts as a valid
//     measurement. No timeout is raised.
//   - Counters cannot wrap: the timeout fires first. high_count <= period count always.
//   - Outputs hold their last value between strobes.
//   - rst mid-measurement: drop the partial result, return to WAIT_LOW next cycle.
//   - Pulses shorter than 2 clk cycles may be missed. This is not an error.
//   - Minimum measurable period: 2 cycles.
// CONFIGURATION
//   CLK_FREQ_METER_CHECK_EN defined:
//     On each meas_valid, in_tol <= (|period - EXP_PERIOD| <= TOL), computed as an
//     unsigned difference with no wrap.
//     in_tol is cleared on reset and on timeout; it otherwise holds between strobes.
//   CLK_FREQ_METER_CHECK_EN not defined:
//     in_tol is tied to 0; no comparator logic.
// TESTING  (clk period 20 ns; sim params TIMEOUT=5000, EXP_PERIOD=1000, TOL=10)
//   1. rst=1 for 100 ns, sig_in=0 -> period=0, high_time=0, meas_valid=0, timeout=0, in_tol=0.
//   2. Square wave, period 1000 cycles, high 250 -> meas_valid once per 1000 cycles,
//      first at the 2nd rise; period=1000, high_time=250.
//   3. After 3 edges, hold sig_in high -> timeout=1 exactly 5000 cycles after the last rise,
//      period=0. Resume toggling -> timeout=0 at the 1st rise; valid at the 2nd rise.
//   4. Assert rst mid-period with sig_in high, then release -> outputs 0; no valid until
//      sig low, then two rises.
//   5. CHECK_EN set: period 1005 -> in_tol=1; period 1020 -> in_tol=0.
//      CHECK_EN unset: in_tol=0 always.
//   6. Period exactly 5000 (rise on the timeout cycle) -> meas_valid=1, period=5000, timeout=0.

Source files
------------

// File: rtl/clk_freq_meter.sv
// Slow-signal period / high-time meter with loss-of-signal timeout.
// Optional tolerance check enabled by defining CLK_FREQ_METER_CHECK_EN.
module clk_freq_meter #(
  parameter int CW         = 26,
  parameter int TIMEOUT    = 60_000_000,
  parameter int EXP_PERIOD = 50_000_000,
  parameter int TOL        = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          timeout,
  output logic          in_tol
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARM,
    MEAS
  } state_t;

  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic          s0;
  logic          s1;
  logic          s_prev;
  logic [1:0]    fill;
  logic          sync_ok;
  logic          rise;
  logic          at_limit;
  logic          do_start;
  logic          do_meas;
  logic          do_tmo;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;

  assign rise     = s1 & ~s_prev;
  assign sync_ok  = fill[1];
  assign at_limit = (cnt == TO_C);

  // Synchronizer, edge register and fill tracker; the synchronizer must
  // hold a real sample before WAIT_LOW may trust s1 being low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      s_prev <= 1'b0;
      fill   <= 2'd0;
    end else begin
      s0     <= sig_in;
      s1     <= s0;
      s_prev <= s1;
      if (!sync_ok) fill <= fill + 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOW;
    else     state <= state_nx;
  end

  // Next-state and event decode.
  always_comb begin
    state_nx = state;
    do_start = 1'b0;
    do_meas  = 1'b0;
    do_tmo   = 1'b0;
    unique case (state)
      WAIT_LOW: begin
        if (sync_ok && !s1) state_nx = ARM;
      end
      ARM: begin
        if (rise) begin
          state_nx = MEAS;
          do_start = 1'b1;
        end
      end
      MEAS: begin
        if (rise) begin
          do_meas = 1'b1;
        end else if (at_limit) begin
          state_nx = ARM;
          do_tmo   = 1'b1;
        end
      end
      default: state_nx = WAIT_LOW;
    endcase
  end

  // Period and high-time counters; the rise cycle itself counts as high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (do_start || do_meas) begin
      cnt  <= CW'(1);
      hcnt <= CW'(1);
    end else if (state == MEAS && !do_tmo) begin
      cnt  <= cnt + CW'(1);
      hcnt <= hcnt + CW'(s1);
    end else begin
      cnt  <= '0;
      hcnt <= '0;
    end
  end

  // Result registers, valid strobe and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      if (do_meas) begin
        period    <= cnt;
        high_time <= hcnt;
      end else if (do_tmo) begin
        period    <= '0;
        high_time <= '0;
      end
      if (do_tmo)        timeout <= 1'b1;
      else if (do_start) timeout <= 1'b0;
    end
  end

`ifdef CLK_FREQ_METER_CHECK_EN
  localparam logic [CW-1:0] EXP_C = CW'(EXP_PERIOD);
  localparam logic [CW-1:0] TOL_C = CW'(TOL);

  logic [CW-1:0] diff;

  assign diff = (cnt >= EXP_C) ? (cnt - EXP_C) : (EXP_C - cnt);

  // Tolerance flag, refreshed with every new measurement.
  always_ff @(posedge clk) begin
    if (rst)          in_tol <= 1'b0;
    else if (do_meas) in_tol <= (diff <= TOL_C);
    else if (do_tmo)  in_tol <= 1'b0;
  end
`else
  // No comparator: check parameters fold away to a constant 0.
  assign in_tol = (EXP_PERIOD < 0) && (TOL < 0);
`endif

endmodule
